// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: opcodes, scheduler state encoding and the opcode legality
// helper shared by the bit-serial ALU scheduler.
package serial_alu_pkg;

  localparam int OP_CYCLES_DEFAULT = 5;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAP  = 2'd2,
    S_RESP = 2'd3
  } sched_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_XOR, OP_ADD, OP_AND, OP_SUB: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the requester that did
// not win the last advanced grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant_r;

  // One-hot grant from the current requests and the previous winner
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        if (last_grant_r) begin
          gnt    = 2'b01;
          gnt_id = 1'b0;
        end else begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

  // Remember the winner of each accepted grant; reset favours requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (advance) begin
      last_grant_r <= gnt_id;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/serial_alu_sched.sv
// serial_alu_sched: arbitrates two requesters onto one bit-serial ALU, holds the
// opcode OP_CYCLES clocks and returns flags. SCHED_PERF_CNT_EN adds perf counters.
module serial_alu_sched
  import serial_alu_pkg::*;
#(
  parameter int OP_CYCLES = OP_CYCLES_DEFAULT,
  parameter int W         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_c,
  output logic         resp_carry,
  output logic         resp_sign,
  output logic         resp_zero,
  output logic         resp_err,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_c,
  input  logic         alu_carry,
  input  logic         alu_sign,
  input  logic         alu_zero
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]  perf_ops,
  output logic [15:0]  perf_err
`endif
);

  localparam int               CNT_W    = $clog2(OP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_CYCLES - 1);

  sched_state_t     state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             id_r;
  logic [1:0]       req_s, gnt_s;
  logic             gnt_id_s, hs_s;
  logic [2:0]       sel_op_s;
  logic [W-1:0]     sel_a_s, sel_b_s;

  // Requests only compete while idle, so a response hand-off never overlaps a grant
  assign req_s      = (!rst && (state_r == S_IDLE)) ? {req1_valid, req0_valid} : 2'b00;
  assign req0_ready = gnt_s[0];
  assign req1_ready = gnt_s[1];
  assign hs_s       = |gnt_s;
  assign sel_op_s   = gnt_id_s ? req1_op : req0_op;
  assign sel_a_s    = gnt_id_s ? req1_a  : req0_a;
  assign sel_b_s    = gnt_id_s ? req1_b  : req0_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_s),
    .advance (hs_s),
    .gnt     (gnt_s),
    .gnt_id  (gnt_id_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (hs_s) begin
          state_nxt_s = op_is_legal(sel_op_s) ? S_RUN : S_RESP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_CAP;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_CAP:  state_nxt_s = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand latches, opcode hold, cycle counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      id_r       <= 1'b0;
      alu_op     <= OP_IDLE;
      alu_a      <= {W{1'b0}};
      alu_b      <= {W{1'b0}};
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_c     <= {W{1'b0}};
      resp_carry <= 1'b0;
      resp_sign  <= 1'b0;
      resp_zero  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (hs_s) begin
            id_r  <= gnt_id_s;
            alu_a <= sel_a_s;
            alu_b <= sel_b_s;
            cnt_r <= {CNT_W{1'b0}};
            if (op_is_legal(sel_op_s)) begin
              alu_op <= sel_op_s;
            end else begin
              // Illegal opcodes never reach the ALU; answer straight away
              alu_op     <= OP_IDLE;
              resp_valid <= 1'b1;
              resp_id    <= gnt_id_s;
              resp_c     <= {W{1'b0}};
              resp_carry <= 1'b0;
              resp_sign  <= 1'b0;
              resp_zero  <= 1'b0;
              resp_err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            alu_op <= OP_IDLE;
          end
        end
        S_CAP: begin
          resp_valid <= 1'b1;
          resp_id    <= id_r;
          resp_c     <= alu_c;
          resp_carry <= alu_carry;
          resp_sign  <= alu_sign;
          resp_zero  <= alu_zero;
          resp_err   <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: alu_op <= OP_IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Count completed responses, split by legal versus error
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops <= 16'd0;
      perf_err <= 16'd0;
    end else if ((state_r == S_RESP) && resp_ready) begin
      if (resp_err) begin
        perf_err <= perf_err + 16'd1;
      end else begin
        perf_ops <= perf_ops + 16'd1;
      end
    end else begin
      perf_ops <= perf_ops;
      perf_err <= perf_err;
    end
  end
`endif

endmodule
